// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronises the raw pins, deglitches the clock,
// deserialises 11-bit frames and emits one-cycle byte / parity-error / frame-error strobes.
module ps2_frame_rx #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 4000
) (
   input  logic       clk_32,
   input  logic       reset_n,
   input  logic       ena_2m,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       busy
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]         TMO_LAST   = TW'(TIMEOUT - 1);
   localparam logic [FILTER_LEN-1:0] FILT_ONES  = {FILTER_LEN{1'b1}};
   localparam logic [FILTER_LEN-1:0] FILT_ZEROS = {FILTER_LEN{1'b0}};

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;
   localparam logic [1:0] ST_STOP   = 2'd3;

   logic                  clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
   logic                  dat_meta_q, dat_meta_d, dat_sync_q, dat_sync_d;
   logic [FILTER_LEN-1:0] filt_q, filt_d;
   logic                  clk_f_q, clk_f_d, clk_fd_q, clk_fd_d;
   logic                  fall_s;
   logic [1:0]            state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;
   logic [7:0]            sr_q, sr_d;
   logic                  par_q, par_d;
   logic [TW-1:0]         tmo_q, tmo_d;
   logic [7:0]            byte_q, byte_d;
   logic                  valid_q, valid_d;
   logic                  perr_q, perr_d;
   logic                  ferr_q, ferr_d;
   logic                  busy_q, busy_d;

   // Odd parity holds when data plus parity bit carry an odd number of ones.
   function automatic logic parity_ok(input logic [7:0] data, input logic par);
      parity_ok = ^{data, par};
   endfunction

   // Two-flop synchronisers, clock glitch filter and falling-edge detect.
   always_comb begin
      clk_meta_d = ps2_clk;
      clk_sync_d = clk_meta_q;
      dat_meta_d = ps2_data;
      dat_sync_d = dat_meta_q;
      if (ena_2m) begin
         filt_d   = {filt_q[FILTER_LEN-2:0], clk_sync_q};
         clk_fd_d = clk_f_q;
         if (filt_d == FILT_ONES) begin
            clk_f_d = 1'b1;
         end else if (filt_d == FILT_ZEROS) begin
            clk_f_d = 1'b0;
         end else begin
            clk_f_d = clk_f_q;
         end
      end else begin
         filt_d   = filt_q;
         clk_fd_d = clk_fd_q;
         clk_f_d  = clk_f_q;
      end
      fall_s = ena_2m & clk_fd_q & ~clk_f_q;
   end

   // Frame FSM with inactivity timeout; a falling edge always beats the timeout.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      par_d   = par_q;
      tmo_d   = tmo_q;
      byte_d  = byte_q;
      valid_d = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      if (fall_s) begin
         tmo_d = {TW{1'b0}};
         case (state_q)
            ST_IDLE: begin
               if (!dat_sync_q) begin
                  state_d = ST_DATA;
                  cnt_d   = 3'd0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_DATA: begin
               sr_d  = {dat_sync_q, sr_q[7:1]};
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  state_d = ST_PARITY;
               end else begin
                  state_d = ST_DATA;
               end
            end
            ST_PARITY: begin
               par_d   = dat_sync_q;
               state_d = ST_STOP;
            end
            ST_STOP: begin
               // A bad stop bit outranks a parity failure.
               if (!dat_sync_q) begin
                  ferr_d = 1'b1;
               end else if (parity_ok(sr_q, par_q)) begin
                  byte_d  = sr_q;
                  valid_d = 1'b1;
               end else begin
                  perr_d = 1'b1;
               end
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else if (state_q == ST_IDLE) begin
         tmo_d = {TW{1'b0}};
      end else if (ena_2m) begin
         if (tmo_q == TMO_LAST) begin
            ferr_d  = 1'b1;
            state_d = ST_IDLE;
            tmo_d   = {TW{1'b0}};
         end else begin
            tmo_d = tmo_q + TW'(1);
         end
      end else begin
         tmo_d = tmo_q;
      end
      busy_d = (state_d != ST_IDLE);
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk_32) begin
      if (!reset_n) begin
         clk_meta_q <= 1'b1;
         clk_sync_q <= 1'b1;
         dat_meta_q <= 1'b1;
         dat_sync_q <= 1'b1;
         filt_q     <= FILT_ONES;
         clk_f_q    <= 1'b1;
         clk_fd_q   <= 1'b1;
         state_q    <= ST_IDLE;
         cnt_q      <= 3'd0;
         sr_q       <= 8'd0;
         par_q      <= 1'b0;
         tmo_q      <= {TW{1'b0}};
         byte_q     <= 8'd0;
         valid_q    <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         clk_meta_q <= clk_meta_d;
         clk_sync_q <= clk_sync_d;
         dat_meta_q <= dat_meta_d;
         dat_sync_q <= dat_sync_d;
         filt_q     <= filt_d;
         clk_f_q    <= clk_f_d;
         clk_fd_q   <= clk_fd_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sr_q       <= sr_d;
         par_q      <= par_d;
         tmo_q      <= tmo_d;
         byte_q     <= byte_d;
         valid_q    <= valid_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         busy_q     <= busy_d;
      end
   end

   assign byte_out   = byte_q;
   assign byte_valid = valid_q;
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx; ena_2m is a free-running 1-in-4 enable so the
// 4000-tick timeout fits a short run.
module tb_ps2_frame_rx;

   logic       clk_32   = 1'b0;
   logic       reset_n  = 1'b0;
   logic       ena_2m   = 1'b0;
   logic       ps2_clk  = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] byte_out;
   logic       byte_valid, parity_err, frame_err, busy;

   int checks   = 0;
   int failures = 0;
   int n_valid  = 0;
   int n_perr   = 0;
   int n_ferr   = 0;
   int n_multi  = 0;
   int n_wide   = 0;
   int ena_div  = 0;
   logic       pv = 1'b0, pp = 1'b0, pf = 1'b0;
   logic [7:0] vlog[$];

   ps2_frame_rx #(.FILTER_LEN(8), .TIMEOUT(4000)) dut (
      .clk_32    (clk_32),
      .reset_n   (reset_n),
      .ena_2m    (ena_2m),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .byte_out  (byte_out),
      .byte_valid(byte_valid),
      .parity_err(parity_err),
      .frame_err (frame_err),
      .busy      (busy)
   );

   initial forever #5 clk_32 = ~clk_32;

   initial forever begin
      @(negedge clk_32);
      ena_2m  = (ena_div == 3);
      ena_div = (ena_div + 1) % 4;
   end

   // Pulse bookkeeping, sampled on the falling edge.
   always @(negedge clk_32) begin
      if (byte_valid) begin
         n_valid++;
         vlog.push_back(byte_out);
      end
      if (parity_err) n_perr++;
      if (frame_err) n_ferr++;
      if ((int'(byte_valid) + int'(parity_err) + int'(frame_err)) > 1) n_multi++;
      if ((byte_valid && pv) || (parity_err && pp) || (frame_err && pf)) n_wide++;
      pv = byte_valid;
      pp = parity_err;
      pf = frame_err;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_32);
         while (ena_2m !== 1'b1) @(posedge clk_32);
      end
      @(negedge clk_32);
   endtask

   task automatic ps2_bit(input logic b, input int q);
      ticks(q);
      ps2_data = b;
      ticks(q);
      ps2_clk = 1'b0;
      ticks(2 * q);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic flip, input logic stop,
                             input int q, input string tag);
      ps2_bit(1'b0, q);
      chk({tag, "_busy_open"}, {31'd0, busy}, 32'd1);
      for (int i = 0; i < 8; i++) ps2_bit(b[i], q);
      ps2_bit((~^b) ^ flip, q);
      ps2_bit(stop, q);
      ps2_data = 1'b1;
      ticks(2);
      chk({tag, "_busy_closed"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      repeat (4) @(negedge clk_32);
      chk("rst_byte",  {24'd0, byte_out},   32'h00);
      chk("rst_valid", {31'd0, byte_valid}, 32'd0);
      chk("rst_perr",  {31'd0, parity_err}, 32'd0);
      chk("rst_ferr",  {31'd0, frame_err},  32'd0);
      chk("rst_busy",  {31'd0, busy},       32'd0);
      reset_n = 1'b1;
      ticks(20);

      send_frame(8'h1C, 1'b0, 1'b1, 40, "t1");
      chk("t1_nvalid", n_valid, 32'd1);
      chk("t1_byte", {24'd0, byte_out}, 32'h1C);
      chk("t1_nperr", n_perr, 32'd0);
      chk("t1_nferr", n_ferr, 32'd0);

      send_frame(8'hF0, 1'b1, 1'b1, 6, "t2");
      chk("t2_nperr", n_perr, 32'd1);
      chk("t2_nvalid", n_valid, 32'd1);
      chk("t2_byte_held", {24'd0, byte_out}, 32'h1C);

      send_frame(8'hAA, 1'b0, 1'b0, 6, "t3");
      chk("t3_nferr", n_ferr, 32'd1);
      chk("t3_nvalid", n_valid, 32'd1);
      chk("t3_nperr", n_perr, 32'd1);
      chk("t3_byte_held", {24'd0, byte_out}, 32'h1C);

      ps2_data = 1'b0;
      ticks(2);
      ps2_clk = 1'b0;
      ticks(7);
      ps2_clk = 1'b1;
      ticks(2);
      ps2_data = 1'b1;
      ticks(20);
      chk("t4_glitch_busy", {31'd0, busy}, 32'd0);
      ps2_clk = 1'b0;
      ticks(12);
      chk("t4_spurious_busy_low", {31'd0, busy}, 32'd0);
      ps2_clk = 1'b1;
      ticks(12);
      chk("t4_spurious_busy", {31'd0, busy}, 32'd0);
      chk("t4_pulses", n_valid + n_perr + n_ferr, 32'd3);

      ps2_bit(1'b0, 6);
      ps2_bit(1'b1, 6);
      ps2_bit(1'b0, 6);
      ps2_bit(1'b1, 6);
      ps2_bit(1'b1, 6);
      chk("t5_busy_open", {31'd0, busy}, 32'd1);
      ticks(3990);
      chk("t5_busy_before_tmo", {31'd0, busy}, 32'd1);
      chk("t5_nferr_before_tmo", n_ferr, 32'd1);
      ticks(15);
      chk("t5_nferr_after_tmo", n_ferr, 32'd2);
      chk("t5_busy_after_tmo", {31'd0, busy}, 32'd0);
      chk("t5_nvalid_tmo", n_valid, 32'd1);
      send_frame(8'h12, 1'b0, 1'b1, 6, "t5b");
      chk("t5_nvalid", n_valid, 32'd2);
      chk("t5_byte", {24'd0, byte_out}, 32'h12);

      ps2_bit(1'b0, 6);
      ps2_bit(1'b1, 6);
      ps2_bit(1'b1, 6);
      ps2_bit(1'b0, 6);
      ps2_bit(1'b0, 6);
      reset_n = 1'b0;
      @(negedge clk_32);
      reset_n = 1'b1;
      chk("t6_rst_byte", {24'd0, byte_out}, 32'h00);
      chk("t6_rst_busy", {31'd0, busy}, 32'd0);
      ticks(30);
      chk("t6_busy_idle", {31'd0, busy}, 32'd0);
      chk("t6_no_pulses", n_valid + n_perr + n_ferr, 32'd5);
      send_frame(8'hE0, 1'b0, 1'b1, 6, "t6a");
      send_frame(8'h75, 1'b0, 1'b1, 6, "t6b");
      chk("t6_nvalid", n_valid, 32'd4);
      chk("t6_byte", {24'd0, byte_out}, 32'h75);
      chk("t6_log_first", {24'd0, vlog[2]}, 32'hE0);
      chk("t6_log_second", {24'd0, vlog[3]}, 32'h75);
      chk("t6_nerr", n_perr + n_ferr, 32'd3);

      chk("pulse_exclusive", n_multi, 32'd0);
      chk("pulse_width", n_wide, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
